// File: rtl/die_roll_sequencer.sv
// Die roll sequencer: synchronizes and debounces a roll button, spins a
// 1..6 counter while the button is held, and commits the value on release.
// A tumble value animates the display while rolling and mirrors the
// committed roll otherwise.
module die_roll_sequencer #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int TUMBLE_DIV      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       btn,
    output logic [2:0] roll_value,
    output logic       roll_valid,
    output logic       rolling,
    output logic [2:0] tumble_value
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(TUMBLE_DIV + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TUMBLE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        DONE    = 2'd2
    } state_t;

    logic             syncMeta_q;
    logic             syncOut_q;
    logic             db_q,        db_d;
    logic [DB_W-1:0]  dbCnt_q,     dbCnt_d;
    state_t           state_q,     state_d;
    logic [2:0]       cnt6_q,      cnt6_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [2:0]       rollValue_q, rollValue_d;
    logic [2:0]       tumble_q,    tumble_d;
    logic             rolling_q,   rolling_d;

    // Two-flop synchronizer for the raw button; it keeps running while disabled
    // so the debouncer always sees a fresh, metastability-filtered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
        end else begin
            syncMeta_q <= btn;
            syncOut_q  <= syncMeta_q;
        end
    end

    // Debouncer: the filtered level flips only after the synchronized button
    // has disagreed with it for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        db_d    = db_q;
        dbCnt_d = '0;
        if (syncOut_q != db_q) begin
            if (dbCnt_q == DB_LAST) begin
                db_d    = syncOut_q;
                dbCnt_d = '0;
            end else begin
                dbCnt_d = dbCnt_q + DB_W'(1);
            end
        end
    end

    // Roll FSM: spin the 1..6 counter while held, commit on release for one
    // cycle in DONE, and pace the tumble animation with a small divider.
    // The committed value is written on the edge entering DONE so that
    // roll_value is already correct while roll_valid is high.
    always_comb begin
        state_d     = state_q;
        cnt6_d      = cnt6_q;
        div_d       = div_q;
        rollValue_d = rollValue_q;
        tumble_d    = rollValue_q;
        case (state_q)
            IDLE: begin
                if (db_q) begin
                    state_d  = ROLLING;
                    cnt6_d   = 3'd1;
                    div_d    = '0;
                    tumble_d = 3'd1;
                end
            end
            ROLLING: begin
                cnt6_d = (cnt6_q >= 3'd6) ? 3'd1 : cnt6_q + 3'd1;
                if (!db_q) begin
                    state_d     = DONE;
                    rollValue_d = cnt6_d;
                    tumble_d    = cnt6_d;
                end else begin
                    tumble_d = tumble_q;
                    if (div_q == DIV_LAST) begin
                        div_d    = '0;
                        tumble_d = cnt6_d;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt6_d  = 3'd1;
            end
        endcase
        rolling_d = (state_d == ROLLING);
    end

    // State register for debounce and FSM; everything holds while disabled,
    // and reset overrides the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_q        <= 1'b0;
            dbCnt_q     <= '0;
            state_q     <= IDLE;
            cnt6_q      <= 3'd1;
            div_q       <= '0;
            rollValue_q <= 3'd0;
            tumble_q    <= 3'd0;
            rolling_q   <= 1'b0;
        end else if (ena) begin
            db_q        <= db_d;
            dbCnt_q     <= dbCnt_d;
            state_q     <= state_d;
            cnt6_q      <= cnt6_d;
            div_q       <= div_d;
            rollValue_q <= rollValue_d;
            tumble_q    <= tumble_d;
            rolling_q   <= rolling_d;
        end
    end

    // The commit pulse is masked while disabled so a frozen DONE never shows a
    // stretched pulse; it appears on the next enabled cycle instead.
    assign roll_valid   = (state_q == DONE) && ena;
    assign roll_value   = rollValue_q;
    assign rolling      = rolling_q;
    assign tumble_value = tumble_q;

endmodule
